data_mem_access_unit: RTL

// - Memory-stage load/store unit directly upstream of the word-wide data RAM (DEPTH x 32, combinational read, level write, no byte enables).
// - Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word accesses.
// - Performs read-modify-write for sub-word stores and lane extraction plus sign/zero extension for loads.
// - Returns one response per request over a valid/ready handshake.

---
 rtl/data_mem_access_unit_if.sv | 48 ++++
 rtl/data_mem_access_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// data_mem_access_unit_if
// Purpose : groups the request, response and data-RAM signals of the
//           load/store unit into a single bundle.
// Signals :
//   req_valid/req_ready           request handshake
//   req_we/req_funct3             store flag and RV32I size/sign code
//   req_addr/req_wdata            byte address and store data
//   resp_valid/resp_ready         response handshake
//   resp_data/resp_err            extended load result and error flag
//   ram_addr/ram_din/ram_we       word-wide RAM write/read port
//   ram_dout                      combinational RAM read data
// Modports: slave  = the load/store unit
//           master = requester plus RAM (environment side)
// ---------------------------------------------------------------------------
interface data_mem_access_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 6
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;
    logic [AW-1:0]   ram_addr;
    logic [XLEN-1:0] ram_din;
    logic            ram_we;
    logic [XLEN-1:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, ram_dout,
        output req_ready, resp_valid, resp_data, resp_err,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, ram_dout,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// data_mem_access_unit
// Purpose : memory-stage load/store unit in front of a DEPTH x 32 word RAM
//           (combinational read, level write). Turns LB/LH/LW/LBU/LHU and
//           SB/SH/SW requests into word accesses, doing read-modify-write
//           for sub-word stores and lane extract + extension for loads.
// Ports   :
//   i_clk     rising-edge clock
//   i_rst_n   synchronous active-low reset
//   bus       data_mem_access_unit_if.slave (request, response, RAM port)
// Options : define LSU_MISALIGN_TRAP_EN to report misaligned half/word
//           accesses as errors; otherwise low address bits are ignored to
//           force natural alignment.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | ready for a request, decode and latch on req_valid
// S_LOAD   | RAM word addressed, extract lane into resp_data
// S_RMW_RD | RAM word addressed, merge store lane into write word
// S_WRITE  | single-cycle ram_we pulse with merged/full word
// S_RESP   | response held until resp_ready
// ---------------------------------------------------------------------------
module data_mem_access_unit #(
    parameter int DEPTH = 64,
    parameter int XLEN  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    data_mem_access_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] LP_ADDR_LIMIT = XLEN'(4 * DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW+1:0]   r_addr;
    logic [2:0]      r_funct3;
    logic [15:0]     r_wdata_lo;
    logic [XLEN-1:0] r_din;
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_err;

    logic            w_accept;
    logic            w_f3_bad;
    logic            w_misalign;
    logic            w_req_err;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_merged;

    // Request decode, only meaningful while in S_IDLE.
    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_f3_bad = bus.req_we ? !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                 : !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_req_err = w_f3_bad || (bus.req_addr >= LP_ADDR_LIMIT) || w_misalign;

    // Lane extraction; half select uses addr[1] only so unaligned halves
    // fall back to natural alignment when trapping is disabled.
    always_comb begin
        w_byte = bus.ram_dout[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = bus.ram_dout[15:8];
            2'd2:    w_byte = bus.ram_dout[23:16];
            2'd3:    w_byte = bus.ram_dout[31:24];
            default: w_byte = bus.ram_dout[7:0];
        endcase
        w_half = r_addr[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load_data = bus.ram_dout;
        endcase
    end

    // Store data replicated across all lanes, so the mask alone picks the lane.
    always_comb begin
        if (r_funct3[1:0] == 2'b00)
            w_mask = {{(XLEN-8){1'b0}}, 8'hFF} << {r_addr[1:0], 3'b000};
        else
            w_mask = r_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_merged = (bus.ram_dout & ~w_mask) |
                   ((r_funct3[1:0] == 2'b00) ? {4{r_wdata_lo[7:0]}} : {2{r_wdata_lo}}) & w_mask;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.ram_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_req_err)                        w_next = S_RESP;
                    else if (!bus.req_we)                 w_next = S_LOAD;
                    else if (bus.req_funct3[1:0] == 2'b10) w_next = S_WRITE;
                    else                                  w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_WRITE;
            S_WRITE: begin
                // Gated by reset so a reset landing on this cycle drops the write.
                bus.ram_we = i_rst_n;
                w_next     = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr      <= '0;
            r_funct3    <= '0;
            r_wdata_lo  <= '0;
            r_din       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= bus.req_addr[AW+1:0];
                r_funct3    <= bus.req_funct3;
                r_wdata_lo  <= bus.req_wdata[15:0];
                r_din       <= bus.req_wdata;
                r_resp_data <= '0;
                r_resp_err  <= w_req_err;
            end
            if (r_state == S_LOAD)   r_resp_data <= w_load_data;
            if (r_state == S_RMW_RD) r_din       <= w_merged;
        end
    end

    assign bus.ram_addr  = r_addr[AW+1:2];
    assign bus.ram_din   = r_din;
    assign bus.resp_data = r_resp_data;
    assign bus.resp_err  = r_resp_err;
endmodule
